// File: rtl/calendar_defs_pkg.sv
// Shared calendar constants and BCD helpers
// for the millennium clock date path.
package calendar_defs;

  localparam int BCD_W = 4;

  localparam logic [7:0]  MONTH_DEC    = 8'h12;
  localparam logic [7:0]  DAY_FIRST    = 8'h01;
  localparam logic [15:0] YEAR_MAX     = 16'h9999;
  localparam logic [15:0] RST_YEAR_DEF = 16'h2000;

  typedef logic [BCD_W-1:0] digit_t;

  // Returns {carry, ten, unit}; carry set on 99 -> 00.
  function automatic logic [8:0] bcd_inc2(input logic [7:0] v);
    digit_t u;
    digit_t t;
    logic   c;
    u = v[3:0];
    t = v[7:4];
    c = 1'b0;
    if (u < 4'd9) begin
      u = u + 4'd1;
    end else begin
      u = 4'd0;
      if (t < 4'd9) begin
        t = t + 4'd1;
      end else begin
        t = 4'd0;
        c = 1'b1;
      end
    end
    return {c, t, u};
  endfunction

  function automatic logic bcd_ok2(input logic [7:0] v);
    return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9);
  endfunction

endpackage

// File: rtl/day_of_month.sv
// Days in a month for a BCD month/year,
// Gregorian leap rule included.
module day_of_month (
  input  logic [7:0]  month_i,
  input  logic [15:0] year_i,
  output logic [7:0]  max_days_o
);

  logic [6:0] yy;
  logic [6:0] cc;
  logic       leap;

  always_comb begin
    yy = 7'(year_i[7:4]) * 7'd10 + 7'(year_i[3:0]);
    cc = 7'(year_i[15:12]) * 7'd10 + 7'(year_i[11:8]);
    // Century years are leap only when the century is a multiple of 4.
    leap = (yy == 7'd0) ? (cc[1:0] == 2'b00)
                        : (yy[1:0] == 2'b00);
    case (month_i)
      8'h02:   max_days_o = leap ? 8'h29 : 8'h28;
      8'h04,
      8'h06,
      8'h09,
      8'h11:   max_days_o = 8'h30;
      default: max_days_o = 8'h31;
    endcase
  end

endmodule

// File: rtl/date_counter.sv
// BCD day/month/year counter with validated
// parallel load for the millennium clock.
module date_counter
  import calendar_defs::*;
#(
  parameter logic [15:0] RST_YEAR = RST_YEAR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        day_tick,
  input  logic        load,
  input  logic [7:0]  ld_day,
  input  logic [7:0]  ld_month,
  input  logic [15:0] ld_year,
  output logic [3:0]  day_unit,
  output logic [3:0]  day_ten,
  output logic [3:0]  month_unit,
  output logic [3:0]  month_ten,
  output logic [3:0]  year_unit,
  output logic [3:0]  year_ten,
  output logic [3:0]  year_hundered,
  output logic [3:0]  year_thousand,
  output logic        year_wrap,
  output logic        load_err
);

  logic [7:0]  day_q, day_d;
  logic [7:0]  month_q, month_d;
  logic [15:0] year_q, year_d;
  logic        wrap_q, wrap_d;
  logic        err_q, err_d;

  logic [7:0]  max_cur;
  logic [7:0]  max_ld;
  logic [8:0]  day_inc;
  logic [8:0]  mon_inc;
  logic [8:0]  yr_lo;
  logic [8:0]  yr_hi;
  logic        ld_ok;

  day_of_month u_dom_cur (
    .month_i    (month_q),
    .year_i     (year_q),
    .max_days_o (max_cur)
  );

  day_of_month u_dom_ld (
    .month_i    (ld_month),
    .year_i     (ld_year),
    .max_days_o (max_ld)
  );

  assign day_inc = bcd_inc2(day_q);
  assign mon_inc = bcd_inc2(month_q);
  assign yr_lo   = bcd_inc2(year_q[7:0]);
  assign yr_hi   = bcd_inc2(year_q[15:8]);

  assign ld_ok = bcd_ok2(ld_day) && bcd_ok2(ld_month)
              && bcd_ok2(ld_year[7:0]) && bcd_ok2(ld_year[15:8])
              && (ld_month >= 8'h01) && (ld_month <= MONTH_DEC)
              && (ld_day >= DAY_FIRST) && (ld_day <= max_ld);

  always_comb begin
    day_d   = day_q;
    month_d = month_q;
    year_d  = year_q;
    wrap_d  = 1'b0;
    err_d   = 1'b0;
    if (load) begin
      if (ld_ok) begin
        day_d   = ld_day;
        month_d = ld_month;
        year_d  = ld_year;
      end else begin
        err_d = 1'b1;
      end
    end else if (day_tick) begin
      // >= lets an out-of-range day fall back to the 1st.
      if (day_q < max_cur) begin
        day_d = day_inc[7:0];
      end else begin
        day_d = DAY_FIRST;
        if (month_q < MONTH_DEC) begin
          month_d = mon_inc[7:0];
        end else begin
          month_d = 8'h01;
          year_d  = {yr_lo[8] ? yr_hi[7:0] : year_q[15:8], yr_lo[7:0]};
          wrap_d  = (year_q == YEAR_MAX);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      day_q   <= DAY_FIRST;
      month_q <= 8'h01;
      year_q  <= RST_YEAR;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      day_q   <= day_d;
      month_q <= month_d;
      year_q  <= year_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
  end

  assign day_unit      = day_q[3:0];
  assign day_ten       = day_q[7:4];
  assign month_unit    = month_q[3:0];
  assign month_ten     = month_q[7:4];
  assign year_unit     = year_q[3:0];
  assign year_ten      = year_q[7:4];
  assign year_hundered = year_q[11:8];
  assign year_thousand = year_q[15:12];
  assign year_wrap     = wrap_q;
  assign load_err      = err_q;

endmodule
